// File: rtl/muladd_issue_pkg.sv
// Shared definitions for the multiply-add requester/collector.
//  - operand / thread-id widths and packed request/result widths
//  - FSM state encoding (RUN / DRAIN / IDLE)
//  - request and result structs as carried through the hold register and result buffer
package muladd_issue_pkg;

  localparam int MA_OPW  = 64;
  localparam int MA_HTW  = 9;
  localparam int MA_REQW = 3*MA_OPW + MA_HTW;  // 201
  localparam int MA_RESW = MA_OPW + MA_HTW;    // 73

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [MA_OPW-1:0] a;
    logic [MA_OPW-1:0] b;
    logic [MA_OPW-1:0] c;
    logic [MA_HTW-1:0] ht_id;
  } req_t;

  typedef struct packed {
    logic [MA_OPW-1:0] res;
    logic [MA_HTW-1:0] ht_id;
  } res_t;

endpackage

// File: rtl/muladd_issue_fifo.sv
// Show-ahead result FIFO.
//  Ports:
//   ck, rst     clock, async active-high reset
//   push, din   write request / data (a push into a full FIFO without a same-cycle pop is dropped)
//   pop         read request, ignored while empty
//   dout, vld   head entry and its valid; dout reads 0 while empty
//   drop        pulses when a push was discarded because the FIFO was full
//  PIPE != 0: a pushed entry becomes visible the cycle after the push.
//  PIPE == 0: fall-through, a push into an empty FIFO is visible the same cycle.
module muladd_issue_fifo #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 32,
  parameter int PIPE  = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             vld,
  output logic             drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [NW-1:0]    cnt;
  logic             empty, full, wr, rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == NW'(DEPTH));

  generate
    if (PIPE != 0) begin : g_reg
      assign vld  = !empty;
      assign dout = empty ? '0 : mem[rptr];
      assign rd   = pop & !empty;
      assign wr   = push & (!full | rd);
    end else begin : g_ft
      // Push and pop of the same entry into an empty FIFO never touch storage.
      logic bypass;
      assign bypass = empty & push & pop;
      assign vld    = !empty | push;
      assign dout   = !empty ? mem[rptr] : (push ? din : '0);
      assign rd     = pop & !empty;
      assign wr     = push & (!full | rd) & !bypass;
    end
  endgenerate

  assign drop = push & full & !rd;

  always_ff @(posedge ck) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= (wptr == AW'(DEPTH-1)) ? '0 : wptr + AW'(1);
      if (rd) rptr <= (rptr == AW'(DEPTH-1)) ? '0 : rptr + AW'(1);
      case ({wr, rd})
        2'b10:   cnt <= cnt + NW'(1);
        2'b01:   cnt <= cnt - NW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/muladd_issue.sv
// Requester/collector in front of the a+b*c multiply-add unit.
//  Thread side : i_req_* / o_req_rdy request handshake; o_res_* / i_res_rdy result return.
//  Unit side   : o_vld/o_a/o_b/o_c/o_htId issue push under i_rdy (unit not almost-full);
//                i_res_vld/i_res/i_res_htId results with no backpressure.
//  Control     : i_drain quiesce request, o_drained quiesced flag, o_err sticky protocol error.
//  Credits bound buffered + in-flight results to RES_DEPTH so the buffer never overflows
//  in correct operation; any overflow or orphan result is flagged on o_err.
module muladd_issue
  import muladd_issue_pkg::*;
#(
  parameter int RES_DEPTH = 32,
  parameter int CW        = 6
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              i_req_vld,
  input  logic [MA_OPW-1:0] i_req_a,
  input  logic [MA_OPW-1:0] i_req_b,
  input  logic [MA_OPW-1:0] i_req_c,
  input  logic [MA_HTW-1:0] i_req_htId,
  output logic              o_req_rdy,
  output logic              o_vld,
  output logic [MA_OPW-1:0] o_a,
  output logic [MA_OPW-1:0] o_b,
  output logic [MA_OPW-1:0] o_c,
  output logic [MA_HTW-1:0] o_htId,
  input  logic              i_rdy,
  input  logic              i_res_vld,
  input  logic [MA_OPW-1:0] i_res,
  input  logic [MA_HTW-1:0] i_res_htId,
  output logic              o_res_vld,
  output logic [MA_OPW-1:0] o_res,
  output logic [MA_HTW-1:0] o_res_htId,
  input  logic              i_res_rdy,
  input  logic              i_drain,
  output logic              o_drained,
  output logic              o_err
);

  state_e          state, state_nxt;
  req_t            hold_q;
  logic            hold_vld;
  logic [CW-1:0]   credits, outstanding;
  logic            issue, accept, pop;
  logic            res_orphan, res_dec, cred_ovf, buf_drop;
  res_t            buf_din, buf_dout;

  // ---------------------------------------------------------------- request / issue
  assign issue     = hold_vld & i_rdy & (credits != '0);
  // Gated by rst so the ready reads 0 while reset is held.
  assign o_req_rdy = !rst & (state == ST_RUN) & (!hold_vld | issue);
  assign accept    = i_req_vld & o_req_rdy;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else if (accept) begin
      hold_vld <= 1'b1;
      hold_q   <= '{a: i_req_a, b: i_req_b, c: i_req_c, ht_id: i_req_htId};
    end else if (issue) begin
      hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      o_vld  <= 1'b0;
      o_a    <= '0;
      o_b    <= '0;
      o_c    <= '0;
      o_htId <= '0;
    end else begin
      o_vld <= issue;
      if (issue) begin
        o_a    <= hold_q.a;
        o_b    <= hold_q.b;
        o_c    <= hold_q.c;
        o_htId <= hold_q.ht_id;
      end
    end
  end

  // ---------------------------------------------------------------- credits / outstanding
  assign pop        = o_res_vld & i_res_rdy;
  // A pop with nothing to give back means the buffer held an entry we never issued.
  assign cred_ovf   = pop & !issue & (credits == CW'(RES_DEPTH));
  assign res_orphan = i_res_vld & (outstanding == '0);
  assign res_dec    = i_res_vld & !res_orphan;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      credits <= CW'(RES_DEPTH);
    end else if (issue & !pop) begin
      credits <= credits - CW'(1);
    end else if (pop & !issue & !cred_ovf) begin
      credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (issue & !res_dec) begin
      outstanding <= outstanding + CW'(1);
    end else if (res_dec & !issue) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  // ---------------------------------------------------------------- result buffer
  assign buf_din = '{res: i_res, ht_id: i_res_htId};

  muladd_issue_fifo #(
    .WIDTH (MA_RESW),
    .DEPTH (RES_DEPTH),
    .PIPE  (1)
  ) u_res_buf (
    .ck   (ck),
    .rst  (rst),
    .push (i_res_vld),
    .din  (buf_din),
    .pop  (pop),
    .dout (buf_dout),
    .vld  (o_res_vld),
    .drop (buf_drop)
  );

  assign o_res      = buf_dout.res;
  assign o_res_htId = buf_dout.ht_id;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) o_err <= 1'b0;
    else     o_err <= o_err | res_orphan | buf_drop | cred_ovf;
  end

  // ---------------------------------------------------------------- drain FSM
  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (i_drain) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!i_drain)
          state_nxt = ST_RUN;
        else if (!hold_vld && (outstanding == '0) && !o_res_vld)
          state_nxt = ST_IDLE;
      end
      ST_IDLE:  if (!i_drain) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Registered from the next state so it tracks state==IDLE exactly, from a flop.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) o_drained <= 1'b0;
    else     o_drained <= (state_nxt == ST_IDLE);
  end

endmodule
